trilat_point_select: RTL and testbench



---
 rtl/trilat_point_select_if.sv | 39 +++
 rtl/trilat_point_select.sv | 175 +++++++++++++++++
 tb/tb_trilat_point_select.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/trilat_point_select_if.sv
`default_nettype none
// ============================================================================
// Module   : trilat_point_select_if
// Brief    : Beat-in / estimate-out handshake bundle for trilat_point_select.
// Revision : 1.0 - initial release
// ============================================================================
interface trilat_point_select_if #(
    parameter int N     = 8,
    parameter int LOG_M = 2
);
    localparam int C_M = 1 << LOG_M;

    logic                in_valid;
    logic                in_ready;
    logic signed [N+1:0] x1P;
    logic signed [N+1:0] y1P;
    logic signed [N+1:0] x2P;
    logic signed [N+1:0] y2P;
    logic signed [N-1:0] xR;
    logic signed [N-1:0] yR;
    logic        [N:0]   rR;

    logic                out_valid;
    logic                out_ready;
    logic signed [N+1:0] out_x;
    logic signed [N+1:0] out_y;
    logic [C_M-1:0]      out_sel;

    modport master (
        output in_valid, x1P, y1P, x2P, y2P, xR, yR, rR, out_ready,
        input  in_ready, out_valid, out_x, out_y, out_sel
    );

    modport slave (
        input  in_valid, x1P, y1P, x2P, y2P, xR, yR, rR, out_ready,
        output in_ready, out_valid, out_x, out_y, out_sel
    );
endinterface
`default_nettype wire

// File: rtl/trilat_point_select.sv
`default_nettype none
// ============================================================================
// Module   : trilat_point_select
// Brief    : Per beat keeps the intersection candidate whose squared distance
//            to a reference anchor best matches its squared radius, and emits
//            the floor mean of M kept points.
// Revision : 1.0 - initial release
// ============================================================================
module trilat_point_select #(
    parameter int N     = 8,
    parameter int LOG_M = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    trilat_point_select_if.slave bus
);
    localparam int C_M  = 1 << LOG_M;
    localparam int C_AW = N + 2 + LOG_M;
    localparam int C_EW = 2 * N + 8;

    typedef enum logic [1:0] {
        COLLECT = 2'd0,
        EVAL    = 2'd1,
        DONE    = 2'd2
    } state_t;

    state_t r_state;
    state_t w_state_next;

    logic signed [N+1:0]  r_x1;
    logic signed [N+1:0]  r_y1;
    logic signed [N+1:0]  r_x2;
    logic signed [N+1:0]  r_y2;
    logic signed [N-1:0]  r_xr;
    logic signed [N-1:0]  r_yr;
    logic        [N:0]    r_rr;

    logic [LOG_M-1:0]     r_cnt;
    logic signed [C_AW-1:0] r_acc_x;
    logic signed [C_AW-1:0] r_acc_y;
    logic [C_M-1:0]       r_sel;
    logic signed [N+1:0]  r_out_x;
    logic signed [N+1:0]  r_out_y;

    logic [C_EW-1:0]      w_err1;
    logic [C_EW-1:0]      w_err2;
    logic                 w_pick2;
    logic signed [N+1:0]  w_px;
    logic signed [N+1:0]  w_py;
    logic signed [C_AW-1:0] w_acc_x_nxt;
    logic signed [C_AW-1:0] w_acc_y_nxt;
    logic signed [N+1:0]  w_avg_x;
    logic signed [N+1:0]  w_avg_y;
    logic                 w_last;

    // |(xp-xr)^2 + (yp-yr)^2 - rr^2|, exact in C_EW bits.
    function automatic logic [C_EW-1:0] point_err(
        input logic signed [N+1:0] xp,
        input logic signed [N+1:0] yp,
        input logic signed [N-1:0] xr,
        input logic signed [N-1:0] yr,
        input logic        [N:0]   rr
    );
        logic signed [N+2:0]    dx;
        logic signed [N+2:0]    dy;
        logic signed [C_EW-1:0] dxe;
        logic signed [C_EW-1:0] dye;
        logic signed [C_EW-1:0] d2;
        logic signed [C_EW-1:0] r2;
        logic signed [C_EW-1:0] diff;
        logic        [2*N+1:0]  r2u;
        dx   = {xp[N+1], xp} - {{3{xr[N-1]}}, xr};
        dy   = {yp[N+1], yp} - {{3{yr[N-1]}}, yr};
        dxe  = {{(C_EW-N-3){dx[N+2]}}, dx};
        dye  = {{(C_EW-N-3){dy[N+2]}}, dy};
        d2   = dxe * dxe + dye * dye;
        r2u  = rr * rr;
        r2   = {{(C_EW-2*N-2){1'b0}}, r2u};
        diff = d2 - r2;
        return diff[C_EW-1] ? -diff : diff;
    endfunction

    assign w_err1  = point_err(r_x1, r_y1, r_xr, r_yr, r_rr);
    assign w_err2  = point_err(r_x2, r_y2, r_xr, r_yr, r_rr);
    assign w_pick2 = (w_err2 < w_err1);
    assign w_px    = w_pick2 ? r_x2 : r_x1;
    assign w_py    = w_pick2 ? r_y2 : r_y1;

    assign w_acc_x_nxt = r_acc_x + {{LOG_M{w_px[N+1]}}, w_px};
    assign w_acc_y_nxt = r_acc_y + {{LOG_M{w_py[N+1]}}, w_py};

    // Dropping the low LOG_M bits of a two's-complement sum is the floor shift.
    assign w_avg_x = w_acc_x_nxt[C_AW-1:LOG_M];
    assign w_avg_y = w_acc_y_nxt[C_AW-1:LOG_M];
    assign w_last  = &r_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= COLLECT;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            COLLECT: if (bus.in_valid)  w_state_next = EVAL;
            EVAL:    w_state_next = w_last ? DONE : COLLECT;
            DONE:    if (bus.out_ready) w_state_next = COLLECT;
            default: w_state_next = COLLECT;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_x1    <= '0;
            r_y1    <= '0;
            r_x2    <= '0;
            r_y2    <= '0;
            r_xr    <= '0;
            r_yr    <= '0;
            r_rr    <= '0;
            r_cnt   <= '0;
            r_acc_x <= '0;
            r_acc_y <= '0;
            r_sel   <= '0;
            r_out_x <= '0;
            r_out_y <= '0;
        end else begin
            case (r_state)
                COLLECT: begin
                    if (bus.in_valid) begin
                        r_x1 <= bus.x1P;
                        r_y1 <= bus.y1P;
                        r_x2 <= bus.x2P;
                        r_y2 <= bus.y2P;
                        r_xr <= bus.xR;
                        r_yr <= bus.yR;
                        r_rr <= bus.rR;
                    end
                end
                EVAL: begin
                    r_acc_x      <= w_acc_x_nxt;
                    r_acc_y      <= w_acc_y_nxt;
                    r_sel[r_cnt] <= w_pick2;
                    r_cnt        <= r_cnt + 1'b1;
                    if (w_last) begin
                        r_out_x <= w_avg_x;
                        r_out_y <= w_avg_y;
                    end
                end
                DONE: begin
                    // Estimate is held in r_out_*; only the collection state restarts.
                    if (bus.out_ready) begin
                        r_acc_x <= '0;
                        r_acc_y <= '0;
                        r_cnt   <= '0;
                        r_sel   <= '0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.in_ready  = (r_state == COLLECT);
    assign bus.out_valid = (r_state == DONE);
    assign bus.out_x     = r_out_x;
    assign bus.out_y     = r_out_y;
    assign bus.out_sel   = r_sel;

endmodule
`default_nettype wire

// File: tb/tb_trilat_point_select.sv
`default_nettype none
// ============================================================================
// Module   : tb_trilat_point_select
// Brief    : Table-driven and randomized self-checking bench for
//            trilat_point_select against an integer reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_trilat_point_select;
    localparam int N     = 8;
    localparam int LOG_M = 2;
    localparam int M     = 1 << LOG_M;

    typedef struct packed {
        logic signed [N+1:0] x1;
        logic signed [N+1:0] y1;
        logic signed [N+1:0] x2;
        logic signed [N+1:0] y2;
        logic signed [N-1:0] xr;
        logic signed [N-1:0] yr;
        logic        [N:0]   rr;
    } beat_t;

    typedef struct packed {
        beat_t [M-1:0]       b;
        logic signed [N+1:0] ex;
        logic signed [N+1:0] ey;
        logic [M-1:0]        esel;
    } vec_t;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_bad;
    vec_t tbl[$];

    trilat_point_select_if #(.N(N), .LOG_M(LOG_M)) bus ();
    trilat_point_select #(.N(N), .LOG_M(LOG_M)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    task automatic check(input string name, input longint got, input longint exp);
        n_cmp++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, required %0d", name, got, exp);
        end
    endtask

    // Reference: squared-distance error and floor mean in plain integer arithmetic.
    function automatic longint perr(input longint x, input longint y, input longint xr,
                                    input longint yr, input longint rr);
        longint e;
        e = (x - xr) * (x - xr) + (y - yr) * (y - yr) - rr * rr;
        return (e < 0) ? -e : e;
    endfunction

    function automatic longint floor_div(input longint s, input longint m);
        if (s >= 0) return s / m;
        return -((-s + m - 1) / m);
    endfunction

    function automatic beat_t mk_beat(input int x1, input int y1, input int x2, input int y2,
                                      input int xr, input int yr, input int rr);
        beat_t r;
        r.x1 = x1[N+1:0];
        r.y1 = y1[N+1:0];
        r.x2 = x2[N+1:0];
        r.y2 = y2[N+1:0];
        r.xr = xr[N-1:0];
        r.yr = yr[N-1:0];
        r.rr = rr[N:0];
        return r;
    endfunction

    function automatic vec_t mk_vec(input beat_t b0, input beat_t b1, input beat_t b2,
                                    input beat_t b3, input int ex, input int ey, input int esel);
        vec_t v;
        v.b[0] = b0;
        v.b[1] = b1;
        v.b[2] = b2;
        v.b[3] = b3;
        v.ex   = ex[N+1:0];
        v.ey   = ey[N+1:0];
        v.esel = esel[M-1:0];
        return v;
    endfunction

    task automatic do_beat(input beat_t b);
        int w;
        bus.x1P      = b.x1;
        bus.y1P      = b.y1;
        bus.x2P      = b.x2;
        bus.y2P      = b.y2;
        bus.xR       = b.xr;
        bus.yR       = b.yr;
        bus.rR       = b.rr;
        bus.in_valid = 1'b1;
        w = 0;
        while (!bus.in_ready && w < 20) begin
            @(posedge clk); #1;
            w++;
        end
        if (!bus.in_ready) check("accept_timeout", longint'(bus.in_ready), 1);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic run_vec(input vec_t v, input int hold, input string tag);
        int w;
        for (int i = 0; i < M; i++) do_beat(v.b[i]);
        check({tag, "_valid_early"}, longint'(bus.out_valid), 0);
        @(posedge clk); #1;
        check({tag, "_valid_rise"}, longint'(bus.out_valid), 1);
        w = 0;
        while (!bus.out_valid && w < 20) begin
            @(posedge clk); #1;
            w++;
        end
        check({tag, "_x"}, bus.out_x, v.ex);
        check({tag, "_y"}, bus.out_y, v.ey);
        check({tag, "_sel"}, longint'(bus.out_sel), longint'(v.esel));
        check({tag, "_in_ready_done"}, longint'(bus.in_ready), 0);
        for (int h = 0; h < hold; h++) begin
            bus.in_valid = 1'b1;
            bus.x1P      = 10'($urandom_range(0, 1023));
            bus.x2P      = 10'($urandom_range(0, 1023));
            @(posedge clk); #1;
            check({tag, "_hold_valid"}, longint'(bus.out_valid), 1);
            check({tag, "_hold_in_ready"}, longint'(bus.in_ready), 0);
            check({tag, "_hold_x"}, bus.out_x, v.ex);
            check({tag, "_hold_y"}, bus.out_y, v.ey);
            check({tag, "_hold_sel"}, longint'(bus.out_sel), longint'(v.esel));
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        check({tag, "_in_ready_after"}, longint'(bus.in_ready), 1);
        check({tag, "_valid_after"}, longint'(bus.out_valid), 0);
        check({tag, "_sel_cleared"}, longint'(bus.out_sel), 0);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

    initial begin
        beat_t nom;
        beat_t p2;
        beat_t tie;
        n_cmp = 0;
        n_bad = 0;
        clk   = 1'b0;
        rst   = 1'b1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.x1P = '0; bus.y1P = '0; bus.x2P = '0; bus.y2P = '0;
        bus.xR  = '0; bus.yR  = '0; bus.rR  = '0;

        nom = mk_beat(10, 0, 50, 50, 0, 0, 10);
        p2  = mk_beat(40, 40, -6, 8, 0, 0, 10);
        tie = mk_beat(10, 0, 0, 10, 0, 0, 10);
        tbl.push_back(mk_vec(nom, nom, nom, nom, 10, 0, 0));
        tbl.push_back(mk_vec(p2, p2, p2, p2, -6, 8, 15));
        tbl.push_back(mk_vec(p2, nom, p2, nom, 2, 4, 5));
        tbl.push_back(mk_vec(tie, tie, tie, tie, 10, 0, 0));
        tbl.push_back(mk_vec(mk_beat(-1, -1, 100, 100, 0, 0, 1), mk_beat(-1, -1, 100, 100, 0, 0, 1),
                             mk_beat(-1, -1, 100, 100, 0, 0, 1), mk_beat(-2, -2, 100, 100, 0, 0, 1),
                             -2, -2, 0));
        tbl.push_back(mk_vec(mk_beat(511, 511, -511, -511, 127, 127, 0), mk_beat(511, 511, -511, -511, 127, 127, 0),
                             mk_beat(511, 511, -511, -511, 127, 127, 0), mk_beat(511, 511, -511, -511, 127, 127, 0),
                             511, 511, 0));
        tbl.push_back(mk_vec(mk_beat(-511, -511, 511, 511, -128, -128, 0), mk_beat(-511, -511, 511, 511, -128, -128, 0),
                             mk_beat(-511, -511, 511, 511, -128, -128, 0), mk_beat(-511, -511, 511, 511, -128, -128, 0),
                             -511, -511, 0));

        #3;
        check("rst_in_ready", longint'(bus.in_ready), 1);
        check("rst_out_valid", longint'(bus.out_valid), 0);
        check("rst_out_x", bus.out_x, 0);
        check("rst_out_y", bus.out_y, 0);
        check("rst_out_sel", longint'(bus.out_sel), 0);
        #4;
        rst = 1'b0;
        @(posedge clk); #1;

        for (int k = 0; k < tbl.size(); k++) run_vec(tbl[k], 0, $sformatf("vec%0d", k));

        // Backpressure, then a clean estimate proves the accumulators restarted at zero.
        run_vec(tbl[1], 5, "bp");
        run_vec(tbl[0], 0, "bp_next");

        // Asynchronous reset after two accepted beats.
        do_beat(p2);
        do_beat(p2);
        rst = 1'b1;
        #1;
        check("midrst_out_valid", longint'(bus.out_valid), 0);
        check("midrst_in_ready", longint'(bus.in_ready), 1);
        check("midrst_out_sel", longint'(bus.out_sel), 0);
        #3;
        rst = 1'b0;
        @(posedge clk); #1;
        run_vec(tbl[0], 0, "post_rst");

        for (int k = 0; k < 20; k++) begin
            vec_t   v;
            longint sx;
            longint sy;
            longint e1;
            longint e2;
            sx = 0;
            sy = 0;
            for (int i = 0; i < M; i++) begin
                v.b[i] = mk_beat(int'($urandom_range(0, 1023)) - 512, int'($urandom_range(0, 1023)) - 512,
                                 int'($urandom_range(0, 1023)) - 512, int'($urandom_range(0, 1023)) - 512,
                                 int'($urandom_range(0, 255)) - 128, int'($urandom_range(0, 255)) - 128,
                                 int'($urandom_range(0, 511)));
                e1 = perr($signed(v.b[i].x1), $signed(v.b[i].y1), $signed(v.b[i].xr), $signed(v.b[i].yr),
                          longint'(v.b[i].rr));
                e2 = perr($signed(v.b[i].x2), $signed(v.b[i].y2), $signed(v.b[i].xr), $signed(v.b[i].yr),
                          longint'(v.b[i].rr));
                v.esel[i] = (e2 < e1);
                sx += (e2 < e1) ? longint'($signed(v.b[i].x2)) : longint'($signed(v.b[i].x1));
                sy += (e2 < e1) ? longint'($signed(v.b[i].y2)) : longint'($signed(v.b[i].y1));
            end
            v.ex = (N+2)'(floor_div(sx, M));
            v.ey = (N+2)'(floor_div(sy, M));
            run_vec(v, k % 3, $sformatf("rand%0d", k));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
`default_nettype wire
